// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks stim through every N-bit vector, holds each
// for HOLD cycles, and scores dut_f against the expected truth table TT.
module truth_table_sweeper #(
  parameter int                N    = 4,
  parameter int                HOLD = 2,
  parameter logic [(1<<N)-1:0] TT   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dut_f,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail
);

  localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]   STIM_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  stim_q, stim_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N:0]    err_q, err_d;
  logic          fv_q, fv_d;
  logic [N-1:0]  ff_q, ff_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          mism;

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mism    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          stim_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          // Four-state compare so an X/Z from the lab block scores as a miss.
          mism = (dut_f !== TT[stim_q]);
          if (mism) begin
            err_d = err_q + 1'b1;
            if (!fv_q) begin
              ff_d = stim_q;
              fv_d = 1'b1;
            end
          end
          hold_d = '0;
          if (stim_q == STIM_LAST) begin
            state_d = S_DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            stim_d = stim_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: a 4-input XOR lab block with injectable faults and a 2-input AND block,
// both scored by the sweeper and checked against a per-vector reference model.
module tb_truth_table_sweeper;

  localparam int          NA = 4, HA = 2, TOT_A = (1 << NA) * HA;
  localparam logic [15:0] TTA = 16'h6996;
  localparam int          NB = 2, HB = 1, TOT_B = (1 << NB) * HB;
  localparam logic [3:0]  TTB = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // instance A: XOR lab block, mask_a flips the block output per vector
  logic          start_a = 1'b0;
  logic [15:0]   mask_a = '0;
  logic          dut_f_a;
  logic [NA-1:0] stim_a, ff_a;
  logic [NA:0]   err_a;
  logic          busy_a, done_a, pass_a, fv_a;

  assign dut_f_a = (^stim_a) ^ mask_a[stim_a];

  truth_table_sweeper #(.N(NA), .HOLD(HA), .TT(TTA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_f(dut_f_a), .stim(stim_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .first_fail(ff_a)
  );

  // instance B: AND lab block, xmask_b replaces the output with xv
  logic          start_b = 1'b0;
  logic [3:0]    xmask_b = '0;
  logic          xv = 1'b0;
  logic          dut_f_b;
  logic [NB-1:0] stim_b, ff_b;
  logic [NB:0]   err_b;
  logic          busy_b, done_b, pass_b, fv_b;

  assign dut_f_b = xmask_b[stim_b] ? xv : (&stim_b);

  truth_table_sweeper #(.N(NB), .HOLD(HB), .TT(TTB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_f(dut_f_b), .stim(stim_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .first_fail(ff_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: misses among vectors whose sampling edge (v+1)*HOLD has passed by cycle j
  function automatic int errs_by(input logic [15:0] m, input int j);
    int c = 0;
    for (int v = 0; v < 16; v++) if (m[v] && (v + 1) * HA <= j) c++;
    return c;
  endfunction

  function automatic int first_by(input logic [15:0] m, input int j);
    for (int v = 0; v < 16; v++) if (m[v] && (v + 1) * HA <= j) return v;
    return 0;
  endfunction

  task automatic chk_reset_a(input string tag);
    chk({tag, ".stim"}, 32'(stim_a), 0);
    chk({tag, ".busy"}, 32'(busy_a), 0);
    chk({tag, ".done"}, 32'(done_a), 0);
    chk({tag, ".pass"}, 32'(pass_a), 0);
    chk({tag, ".err"},  32'(err_a),  0);
    chk({tag, ".fv"},   32'(fv_a),   0);
    chk({tag, ".ff"},   32'(ff_a),   0);
  endtask

  task automatic go_a();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  // Called #1 after the start-accept edge; follows the whole sweep cycle by cycle.
  task automatic track_a(input logic [15:0] m, input int pulse_at);
    int j = 0;
    mask_a = m;
    chk("acc.busy", 32'(busy_a), 1);
    chk("acc.done", 32'(done_a), 0);
    chk("acc.pass", 32'(pass_a), 0);
    chk("acc.stim", 32'(stim_a), 0);
    chk("acc.err",  32'(err_a),  0);
    chk("acc.fv",   32'(fv_a),   0);
    while (j < TOT_A) begin
      @(negedge clk);
      if (pulse_at >= 0) start_a = (j == pulse_at);
      @(posedge clk); #1;
      j++;
      if (j < TOT_A) begin
        chk("run.busy", 32'(busy_a), 1);
        chk("run.done", 32'(done_a), 0);
        chk("run.stim", 32'(stim_a), 32'(j / HA));
        chk("run.err",  32'(err_a),  32'(errs_by(m, j)));
        chk("run.fv",   32'(fv_a),   32'(errs_by(m, j) > 0));
        chk("run.ff",   32'(ff_a),   32'(first_by(m, j)));
      end
    end
    chk("end.done", 32'(done_a), 1);
    chk("end.busy", 32'(busy_a), 0);
    chk("end.stim", 32'(stim_a), 0);
    chk("end.err",  32'(err_a),  32'($countones(m)));
    chk("end.pass", 32'(pass_a), 32'(m == 16'h0));
    chk("end.fv",   32'(fv_a),   32'(m != 16'h0));
    chk("end.ff",   32'(ff_a),   32'(first_by(m, TOT_A)));
  endtask

  task automatic sweep_b(input logic [3:0] xm, input logic xval);
    int cyc = 0;
    int e = 0;
    int f = -1;
    logic fv;
    xmask_b = xm;
    xv = xval;
    for (int v = 0; v < 4; v++) begin
      fv = xm[v] ? xv : (v == 3);
      if (fv !== TTB[v]) begin
        e++;
        if (f < 0) f = v;
      end
    end
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    chk("b.acc.busy", 32'(busy_b), 1);
    while (!done_b && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b.latency", 32'(cyc), TOT_B);
    chk("b.err",  32'(err_b),  32'(e));
    chk("b.pass", 32'(pass_b), 32'(e == 0));
    chk("b.fv",   32'(fv_b),   32'(e != 0));
    chk("b.ff",   32'(ff_b),   32'((f < 0) ? 0 : f));
  endtask

  initial begin
    logic [15:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("rst");
    chk("rst.b.done", 32'(done_b), 0);
    @(negedge clk); rst = 1'b0;

    // matching block, then single fault at 5 and fully inverted (each started from DONE)
    go_a(); track_a(16'h0000, -1);
    go_a(); track_a(16'h0020, -1);
    go_a(); track_a(16'hFFFF, -1);
    // DONE holds its results while idle
    repeat (4) @(posedge clk);
    #1;
    chk("hold.done", 32'(done_a), 1);
    chk("hold.err",  32'(err_a),  16);

    // start pulsed while busy is ignored
    go_a(); track_a(16'h0410, 10);

    // asynchronous reset during vector 7
    go_a();
    mask_a = 16'h0003;
    repeat (15) @(posedge clk);
    #1;
    chk("mid.stim", 32'(stim_a), 7);
    #3; rst = 1'b1;
    #1;
    chk_reset_a("midrst");
    @(negedge clk); rst = 1'b0;
    go_a(); track_a(16'h0000, -1);

    // start held high: back-to-back sweeps
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    track_a(16'h8000, -1);
    @(posedge clk); #1;
    start_a = 1'b0;
    track_a(16'h0100, -1);

    // randomized fault patterns, some dense, some sparse
    for (int i = 0; i < 6; i++) begin
      m = 16'($urandom);
      if (i[0]) m = m & 16'($urandom) & 16'($urandom);
      go_a();
      track_a(m, (i == 2) ? int'($urandom_range(0, TOT_A - 3)) : -1);
    end

    // small configuration: AND block, then X at vector 2
    sweep_b(4'b0000, 1'b0);
    sweep_b(4'b0100, 1'bx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking exhaustive stimulus engine for combinational lab blocks of N inputs and one output. On `start`, it drives every input combination 0 … 2^N−1 onto `stim`, holding each for HOLD cycles. At the end of each window it compares the DUT output against an expected truth table held in a parameter. It replaces hand-written 16-line vector lists with a single clocked block that counts mismatches and reports the first failing vector.

## Interface
- `N`, default 4: DUT input width; `stim` width; sweep covers 2^N vectors. Legal range 1..8.
- `HOLD`, default 2: cycles each vector is held. Must be ≥1.
- `TT`, default 16'h0000: expected truth table, 2^N bits. Bit v is the expected `f` for `stim == v`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a sweep. Sampled only in IDLE or DONE.
- `dut_f` input 1: DUT output under test.
- `stim` output N: vector applied to the DUT; bit N−1 corresponds to input A (MSB).
- `busy` output 1: sweep in progress.
- `done` output 1: sweep finished; sticky until the next accepted `start` or `rst`.
- `pass` output 1: valid with `done`; 1 when `err_count == 0`.
- `err_count` output N+1: number of mismatching vectors. Max 2^N, so it never saturates.
- `fail_valid` output 1: at least one mismatch has been recorded.
- `first_fail` output N: vector index of the first mismatch. Valid when `fail_valid` is 1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start == 1`. Same edge loads `stim = 0`, `hold_cnt = 0`, `err_count = 0`, `fail_valid = 0`, `first_fail = 0`.
- RUN: `hold_cnt` increments each cycle. When `hold_cnt == HOLD−1`:
  - Compare `dut_f` with `TT[stim]`. On a mismatch (including X/Z on `dut_f`, i.e. `!==`), increment `err_count`.
  - If `fail_valid == 0` on a mismatch, also set `first_fail = stim` and `fail_valid = 1`.
  - If `stim != 2^N−1`: `stim` increments and `hold_cnt` returns to 0.
  - If `stim == 2^N−1`: → DONE.
- `stim` increment uses N-bit arithmetic. Termination is by explicit compare with 2^N−1, never by wrap-to-0 detection.
- DONE:
  - `done = 1`, `busy = 0`, `stim = 0`.
  - `pass = (err_count == 0)`, registered on the DONE-entry edge, including the final compare's contribution.
  - Remaining outputs are frozen.
- DONE → RUN on `start == 1`, with the same initialisation as from IDLE. This clears `done` and `pass`.
- `start` in RUN is ignored. Holding `start` high continuously re-triggers a new sweep the cycle after DONE is entered.
- `rst` asserted at any time, including mid-sweep: immediate return to IDLE with all outputs at reset values. No partial results are retained.
- Reset values: `stim = 0`, `busy = 0`, `done = 0`, `pass = 0`, `err_count = 0`, `fail_valid = 0`, `first_fail = 0`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Take the `start`-accept edge as edge k.
- `busy` is high from edge k to edge k+2^N·HOLD.
- Vector v is driven during cycles k+v·HOLD+1 … k+(v+1)·HOLD.
- `dut_f` is sampled at edge k+(v+1)·HOLD. The DUT therefore has HOLD−1 full cycles plus one clock period to settle.
- `done` and `pass` rise at edge k+2^N·HOLD; `busy` falls at the same edge.
- Total sweep latency is 2^N·HOLD cycles. N=4, HOLD=2 gives 32 cycles.
- `err_count`, `first_fail` and `fail_valid` update at the same edge as the sample that causes them.

## Test plan
- Matching DUT: N=4, HOLD=2, TT=16'h6996 (4-input XOR model), one-cycle `start` → `stim` walks 0..15, two cycles each; `done` = 1 exactly 32 cycles after start; `pass` = 1, `err_count` = 0, `fail_valid` = 0.
- Single fault: same setup, DUT output inverted only at `stim == 5` → `err_count` = 1, `first_fail` = 5, `fail_valid` set at the sampling edge of vector 5, `pass` = 0.
- Fully inverted DUT → `err_count` = 16 (5'b10000, no overflow), `first_fail` = 0.
- Reset mid-sweep: assert `rst` asynchronously (off a clock edge) during vector 7 → all outputs at reset values immediately. A new `start` then yields a full 32-cycle sweep with correct results.
- Handshake: `start` pulsed while `busy` → ignored, no restart. `start` in DONE → `done` and `pass` clear at that edge and a fresh sweep begins with `err_count` = 0. `start` held high → back-to-back sweeps.
- Parametrisation: N=2, HOLD=1, TT=4'b1000 (AND), correct DUT → done after 4 cycles, `pass` = 1. Same configuration with X driven on `dut_f` at `stim == 2` → `err_count` = 1, `first_fail` = 2.
